// File: rtl/lsu_axi_master_if.sv
// AXI-lite read/write channel bundle between the LSU master and a data-memory slave.
interface lsu_axi_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/lsu_axi_master.sv
// LSU to AXI-lite master: one outstanding load/store, lane alignment and load extension.
// Optional build macro LSU_MISALIGN_CHECK_EN rejects misaligned half/word accesses locally.
module lsu_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_err,
  lsu_axi_master_if.master  m_axi
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t              r_state;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_resp_err;
  logic [ADDR_W-1:0]   r_araddr;
  logic                r_arvalid;
  logic                r_rready;
  logic [ADDR_W-1:0]   r_awaddr;
  logic                r_awvalid;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic                r_wvalid;
  logic                r_bready;
  logic                r_aw_done;
  logic                r_w_done;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [1:0]          r_addr_lo;

  logic [7:0]          w_rd_byte;
  logic [15:0]         w_rd_half;
  logic [DATA_W-1:0]   w_load_data;
  logic [DATA_W-1:0]   w_st_data;
  logic [DATA_W/8-1:0] w_st_strb;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_accept;

  assign w_accept = i_req_valid & r_req_ready;
  assign w_aw_hs  = r_awvalid & m_axi.awready;
  assign w_w_hs   = r_wvalid & m_axi.wready;

`ifdef LSU_MISALIGN_CHECK_EN
  logic w_misalign;
  assign w_misalign = ((i_req_size == 2'd1) & i_req_addr[0]) |
                      (i_req_size[1] & (i_req_addr[1:0] != 2'b00));
`endif

  // Read lane select and sign/zero extension from the latched size/offset
  always_comb begin
    w_rd_byte = m_axi.rdata[{r_addr_lo, 3'b000} +: 8];
    w_rd_half = r_addr_lo[1] ? m_axi.rdata[31:16] : m_axi.rdata[15:0];
    case (r_size)
      2'd0:    w_load_data = r_unsigned ? {24'd0, w_rd_byte} : {{24{w_rd_byte[7]}}, w_rd_byte};
      2'd1:    w_load_data = r_unsigned ? {16'd0, w_rd_half} : {{16{w_rd_half[15]}}, w_rd_half};
      default: w_load_data = m_axi.rdata;
    endcase
  end

  // Store data replication and byte-strobe generation for the incoming request
  always_comb begin
    case (i_req_size)
      2'd0: begin
        w_st_data = {4{i_req_wdata[7:0]}};
        w_st_strb = 4'b0001 << i_req_addr[1:0];
      end
      2'd1: begin
        w_st_data = {2{i_req_wdata[15:0]}};
        w_st_strb = 4'b0011 << {i_req_addr[1], 1'b0};
      end
      default: begin
        w_st_data = i_req_wdata;
        w_st_strb = 4'b1111;
      end
    endcase
  end

  // Transaction FSM; every bus and core output is a register written here
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
      r_araddr     <= 32'd0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awaddr     <= 32'd0;
      r_awvalid    <= 1'b0;
      r_wdata      <= 32'd0;
      r_wstrb      <= 4'd0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_size       <= 2'd0;
      r_unsigned   <= 1'b0;
      r_addr_lo    <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_size      <= i_req_size;
            r_unsigned  <= i_req_unsigned;
            r_addr_lo   <= i_req_addr[1:0];
`ifdef LSU_MISALIGN_CHECK_EN
            if (w_misalign) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
              r_state      <= DONE;
            end else
`endif
            if (i_req_we) begin
              r_awaddr  <= {i_req_addr[ADDR_W-1:2], 2'b00};
              r_wdata   <= w_st_data;
              r_wstrb   <= w_st_strb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= WR_REQ;
            end else begin
              r_araddr  <= {i_req_addr[ADDR_W-1:2], 2'b00};
              r_arvalid <= 1'b1;
              r_state   <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (m_axi.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi.rvalid) begin
            r_rready     <= 1'b0;
            r_resp_rdata <= w_load_data;
            r_resp_err   <= (m_axi.rresp != 2'b00);
            r_resp_valid <= 1'b1;
            r_state      <= DONE;
          end
        end
        WR_REQ: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          // AW and W may complete in either order or together
          if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
            r_bready <= 1'b1;
            r_state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi.bvalid) begin
            r_bready     <= 1'b0;
            r_resp_err   <= (m_axi.bresp != 2'b00);
            r_resp_rdata <= 32'd0;
            r_resp_valid <= 1'b1;
            r_state      <= DONE;
          end
        end
        DONE: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_req_ready   = r_req_ready;
  assign o_resp_valid  = r_resp_valid;
  assign o_resp_rdata  = r_resp_rdata;
  assign o_resp_err    = r_resp_err;
  assign m_axi.araddr  = r_araddr;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.rready  = r_rready;
  assign m_axi.awaddr  = r_awaddr;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.bready  = r_bready;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: scripted AXI-lite slave tasks plus a response scoreboard.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  lsu_axi_master_if bus ();

  lsu_axi_master dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_we       (req_we),
    .i_req_addr     (req_addr),
    .i_req_size     (req_size),
    .i_req_unsigned (req_unsigned),
    .i_req_wdata    (req_wdata),
    .o_resp_valid   (resp_valid),
    .i_resp_ready   (resp_ready),
    .o_resp_rdata   (resp_rdata),
    .o_resp_err     (resp_err),
    .m_axi          (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_resp   = 0;
  int   ar_pulses = 0;
  int   aw_pulses = 0;
  int   t_acc    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (resp_valid && resp_ready) n_resp <= n_resp + 1;
    if (bus.arvalid) ar_pulses <= ar_pulses + 1;
    if (bus.awvalid || bus.wvalid) aw_pulses <= aw_pulses + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Independent reference for load lane selection and extension.
  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = (d >> (8 * a[1:0])) & 32'h0000_00FF;
        if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        v = (d >> (a[1] ? 16 : 0)) & 32'h0000_FFFF;
        if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd);
    int n;
    req_we = we; req_addr = addr; req_size = sz; req_unsigned = uns; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    check1("req_accept", req_ready, 1'b1);
    t_acc = cyc;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input int hold, input int exp_lat);
    int   n;
    exp_t e;
    n = 0;
    while (!resp_valid && n < 100) begin tick(); n++; end
    check1({tag, "_resp_valid"}, resp_valid, 1'b1);
    if (exp_lat > 0) check({tag, "_latency"}, cyc - t_acc, exp_lat);
    if (sb.size() == 0) begin
      n_assert++; n_fail++;
      $error("FAIL %s_scoreboard: observed empty queue expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_rdata"}, resp_rdata, e.rdata);
      check1({tag, "_err"}, resp_err, e.err);
      for (int i = 0; i < hold; i++) begin
        tick();
        check1({tag, "_hold_valid"}, resp_valid, 1'b1);
        check1({tag, "_hold_err"}, resp_err, e.err);
        check({tag, "_hold_rdata"}, resp_rdata, e.rdata);
        check1({tag, "_hold_req_ready"}, req_ready, 1'b0);
      end
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check1({tag, "_resp_drop"}, resp_valid, 1'b0);
    check1({tag, "_idle_ready"}, req_ready, 1'b1);
  endtask

  task automatic slave_read(input logic [31:0] exp_addr, input int ar_wait, input int r_wait,
                            input logic [31:0] data, input logic [1:0] resp);
    int n;
    n = 0;
    while (!bus.arvalid && n < 50) begin tick(); n++; end
    check1("arvalid_seen", bus.arvalid, 1'b1);
    check("araddr", bus.araddr, exp_addr);
    for (int i = 0; i < ar_wait; i++) begin
      tick();
      check("araddr_hold", bus.araddr, exp_addr);
    end
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    if (r_wait >= 0) begin
      repeat (r_wait) tick();
      bus.rvalid = 1'b1; bus.rdata = data; bus.rresp = resp;
      n = 0;
      while (!bus.rready && n < 50) begin tick(); n++; end
      check1("rready_seen", bus.rready, 1'b1);
      tick();
      bus.rvalid = 1'b0; bus.rdata = 32'd0; bus.rresp = 2'b00;
    end
  endtask

  task automatic slave_write(input logic [31:0] exp_addr, input logic [31:0] exp_data,
                             input logic [3:0] exp_strb, input int aw_wait, input logic w_after,
                             input int b_wait, input logic [1:0] resp);
    int n;
    n = 0;
    while (!bus.awvalid && n < 50) begin tick(); n++; end
    check1("awvalid_seen", bus.awvalid, 1'b1);
    check1("wvalid_with_aw", bus.wvalid, 1'b1);
    check("awaddr", bus.awaddr, exp_addr);
    check("wdata", bus.wdata, exp_data);
    check("wstrb", {28'd0, bus.wstrb}, {28'd0, exp_strb});
    repeat (aw_wait) tick();
    if (w_after) begin
      bus.awready = 1'b1;
      tick();
      bus.awready = 1'b0;
      check1("awvalid_drop", bus.awvalid, 1'b0);
      check1("wvalid_still", bus.wvalid, 1'b1);
      bus.wready = 1'b1;
      tick();
      bus.wready = 1'b0;
    end else begin
      bus.awready = 1'b1; bus.wready = 1'b1;
      tick();
      bus.awready = 1'b0; bus.wready = 1'b0;
    end
    check1("wvalid_drop", bus.wvalid, 1'b0);
    check1("awvalid_off", bus.awvalid, 1'b0);
    check1("bready_on", bus.bready, 1'b1);
    repeat (b_wait) tick();
    bus.bvalid = 1'b1; bus.bresp = resp;
    n = 0;
    while (!bus.bready && n < 50) begin tick(); n++; end
    tick();
    bus.bvalid = 1'b0; bus.bresp = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int ar0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 32'd0; resp_ready = 1'b0;
    bus.arready = 1'b0; bus.rdata = 32'd0; bus.rresp = 2'b00; bus.rvalid = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bresp = 2'b00; bus.bvalid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_valids", {25'd0, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready,
                         bus.bready, resp_valid, resp_err}, 32'd0);
    check1("rst_req_ready", req_ready, 1'b1);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_addrs", bus.araddr | bus.awaddr | bus.wdata | {28'd0, bus.wstrb}, 32'd0);

    // Word load, 3-cycle data delay
    sb.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
    fork
      slave_read(32'h8000_0004, 0, 3, 32'hDEAD_BEEF, 2'b00);
      begin do_req(1'b0, 32'h8000_0004, 2'd2, 1'b0, 32'd0); wait_resp("ld_word", 0, 0); end
    join

    // Signed then unsigned byte load
    sb.push_back('{rdata: 32'hFFFF_FF80, err: 1'b0});
    fork
      slave_read(32'h8000_0000, 1, 0, 32'h80FF_1234, 2'b00);
      begin do_req(1'b0, 32'h8000_0003, 2'd0, 1'b0, 32'd0); wait_resp("ld_sbyte", 0, 0); end
    join
    sb.push_back('{rdata: 32'h0000_0080, err: 1'b0});
    fork
      slave_read(32'h8000_0000, 0, 1, 32'h80FF_1234, 2'b00);
      begin do_req(1'b0, 32'h8000_0003, 2'd0, 1'b1, 32'd0); wait_resp("ld_ubyte", 0, 0); end
    join

    // Zero-wait signed half load with minimum latency, and slave error on a byte load
    sb.push_back('{rdata: ref_load(32'h8001_7FFF, 32'h8000_0002, 2'd1, 1'b0), err: 1'b0});
    fork
      slave_read(32'h8000_0000, 0, 0, 32'h8001_7FFF, 2'b00);
      begin do_req(1'b0, 32'h8000_0002, 2'd1, 1'b0, 32'd0); wait_resp("ld_shalf", 0, 3); end
    join
    sb.push_back('{rdata: ref_load(32'h1234_5678, 32'h8000_0041, 2'd0, 1'b1), err: 1'b1});
    fork
      slave_read(32'h8000_0040, 0, 0, 32'h1234_5678, 2'b11);
      begin do_req(1'b0, 32'h8000_0041, 2'd0, 1'b1, 32'd0); wait_resp("ld_rerr", 0, 0); end
    join

    // Half store, W accepted only after AW
    n0 = n_resp;
    sb.push_back('{rdata: 32'd0, err: 1'b0});
    fork
      slave_write(32'h8000_0000, 32'hABCD_ABCD, 4'b1100, 2, 1'b1, 1, 2'b00);
      begin do_req(1'b1, 32'h8000_0002, 2'd1, 1'b0, 32'h0000_ABCD); wait_resp("st_half", 0, 0); end
    join
    repeat (3) tick();
    check("st_half_one_resp", n_resp - n0, 32'd1);

    // Byte store with AW and W in the same cycle
    sb.push_back('{rdata: 32'd0, err: 1'b0});
    fork
      slave_write(32'h8000_0000, 32'hA5A5_A5A5, 4'b0010, 0, 1'b0, 0, 2'b00);
      begin do_req(1'b1, 32'h8000_0001, 2'd0, 1'b0, 32'h0000_00A5); wait_resp("st_byte", 0, 0); end
    join

    // Word store with SLVERR, response held for 5 cycles
    sb.push_back('{rdata: 32'd0, err: 1'b1});
    fork
      slave_write(32'h8000_0008, 32'h1122_3344, 4'b1111, 0, 1'b0, 1, 2'b10);
      begin do_req(1'b1, 32'h8000_0008, 2'd2, 1'b0, 32'h1122_3344); wait_resp("st_err", 5, 0); end
    join

    // Reset while waiting for read data
    n0 = n_resp;
    fork
      slave_read(32'h8000_0010, 0, -1, 32'd0, 2'b00);
      do_req(1'b0, 32'h8000_0010, 2'd2, 1'b0, 32'd0);
    join
    check1("abort_in_rd_data", bus.rready, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_valids", {26'd0, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready,
                           bus.bready, resp_valid}, 32'd0);
    check1("abort_idle", req_ready, 1'b1);
    repeat (3) tick();
    check("abort_no_resp", n_resp - n0, 32'd0);
    sb.push_back('{rdata: 32'h1234_5678, err: 1'b0});
    fork
      slave_read(32'h8000_0008, 0, 1, 32'h1234_5678, 2'b00);
      begin do_req(1'b0, 32'h8000_0008, 2'd3, 1'b0, 32'd0); wait_resp("after_rst", 0, 0); end
    join

    // Misaligned word load
`ifdef LSU_MISALIGN_CHECK_EN
    ar0 = ar_pulses;
    sb.push_back('{rdata: 32'd0, err: 1'b1});
    do_req(1'b0, 32'h8000_0001, 2'd2, 1'b0, 32'd0);
    check1("mis_resp_next", resp_valid, 1'b1);
    wait_resp("mis_word", 0, 0);
    check("mis_no_ar", ar_pulses - ar0, 32'd0);
    ar0 = aw_pulses;
    sb.push_back('{rdata: 32'd0, err: 1'b1});
    do_req(1'b1, 32'h8000_0003, 2'd1, 1'b0, 32'h0000_BEEF);
    wait_resp("mis_half_st", 0, 0);
    check("mis_no_aw", aw_pulses - ar0, 32'd0);
`else
    ar0 = ar_pulses;
    sb.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
    fork
      slave_read(32'h8000_0000, 0, 0, 32'hCAFE_F00D, 2'b00);
      begin do_req(1'b0, 32'h8000_0001, 2'd2, 1'b0, 32'd0); wait_resp("mis_word", 0, 3); end
    join
    check("mis_ar_forwarded", ar_pulses - ar0, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
- AXI-lite master between the core's load/store unit and the data-memory slave (dsram or any AXI-lite responder).
- Accepts one load/store request at a time over a simple valid/ready port and runs the matching AR/R or AW/W/B transaction.
- Performs byte/half/word lane alignment and mask generation on writes, plus sign/zero extension on reads.
- Returns one response per request; single outstanding transaction.

Parameters:
- ADDR_W, 32, address width; only 32 supported.
- DATA_W, 32, data width; only 32 supported; wstrb is DATA_W/8.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  core request valid
- req_ready  out  1  request accepted when valid&&ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  response valid
- resp_ready  in  1  core accepts response
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  1 = slave returned non-OKAY resp
- araddr  out  32;  arvalid  out  1;  arready  in  1
- rdata  in  32;  rresp  in  2;  rvalid  in  1;  rready  out  1
- awaddr  out  32;  awvalid  out  1;  awready  in  1
- wdata  out  32;  wstrb  out  4;  wvalid  out  1;  wready  in  1
- bresp  in  2;  bvalid  in  1;  bready  out  1

Behaviour:
- Reset (rst=1 at clk edge): state IDLE. All valid outputs and rready/bready are 0. resp_rdata=0, resp_err=0, araddr/awaddr/wdata/wstrb=0. An in-flight transaction is abandoned with no response.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: req_ready=1, all other handshake outputs 0.
  - On accept, latch all req_* fields.
  - Go to WR_REQ if req_we, else RD_ADDR.
- Bus address: araddr/awaddr = {req_addr[31:2],2'b00}, held stable while the corresponding valid is high.
- RD_ADDR: arvalid=1. On arready go to RD_DATA.
- RD_DATA: rready=1. On rvalid:
  - Select lane by addr[1:0] (byte: rdata[8*a+:8]; half: rdata[16*a[1]+:16]).
  - Extend per req_unsigned; register into resp_rdata.
  - resp_err = (rresp!=0). Go to DONE.
- WR_REQ: awvalid and wvalid are asserted together in the first cycle.
  - Separate aw_done/w_done flags; each valid drops after its own handshake.
  - Both handshakes in the same cycle are legal.
  - wvalid must never wait for awready; the slave may raise wready only after AW is accepted.
  - When both are done (including the same cycle), go to WR_RESP.
- Write lanes:
  - wdata = req_wdata replicated (byte: 4x; half: 2x; word: as-is).
  - wstrb = 4'b0001<<a for byte, 4'b0011<<(2*a[1]) for half, 4'b1111 for word.
- WR_RESP: bready=1. On bvalid, resp_err=(bresp!=0), resp_rdata=0, go to DONE.
- DONE: resp_valid=1 and outputs held stable. On resp_ready, go to IDLE.
  - req_ready stays 0 in DONE; there is no same-cycle re-accept.
- Minimum latency, zero-wait slave (arready=1, rvalid the cycle after AR): accept@T, arvalid@T+1, rready@T+2, resp_valid@T+3.
- Misaligned accesses are forwarded unchanged unless the feature below is enabled; lane selection uses the low address bits as-is.
- Stalls of any length on the bus or on resp_ready are tolerated; no timeout.

Optional Feature:
- Macro LSU_MISALIGN_CHECK_EN.
- Defined: on accept, a half access with addr[0]=1 or a word access with addr[1:0]!=0 skips AXI entirely. The block goes IDLE -> DONE next cycle with resp_err=1, resp_rdata=0, and no arvalid/awvalid/wvalid pulse.
- Undefined: no check; behaviour is as described in Behaviour.

Test Plan:
- Word load, addr 0x80000004, slave returns 0xDEADBEEF after a 3-cycle delay:
  - araddr = 0x80000004, resp_rdata = 0xDEADBEEF, resp_err = 0.
- Signed byte load, addr 0x80000003, rdata 0x80FF1234:
  - resp_rdata = 0xFFFFFF80.
  - Same load with req_unsigned=1 gives 0x00000080.
- Half store, addr 0x80000002, wdata 0x0000ABCD, slave asserts wready only after AW is accepted:
  - awaddr = 0x80000000, wdata = 0xABCDABCD, wstrb = 4'b1100.
  - No deadlock; exactly one resp_valid.
- bresp=2'b10 on a word store, then resp_ready held 0 for 5 cycles:
  - resp_valid and resp_err stay 1 and stable.
  - req_ready=0 until resp_ready is asserted.
- rst asserted during RD_DATA:
  - Next cycle all valid/ready outputs are 0 and state is IDLE.
  - A following load completes normally.
- With LSU_MISALIGN_CHECK_EN, word load at 0x80000001:
  - No arvalid pulse; resp_valid the cycle after accept with resp_err = 1.
